// File: rtl/bids22_round_seq.sv
// Auction round sequencer: configures the engine, runs one round, captures the result.
// Optional RUN watchdog is built when BIDS22_SEQ_WATCHDOG_EN is defined.
module bids22_round_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_key,
  input  logic [31:0] cfg_bal_x,
  input  logic [31:0] cfg_bal_y,
  input  logic [31:0] cfg_bal_z,
  input  logic [31:0] cfg_timer,
  input  logic        ready,
  input  logic [2:0]  err,
  input  logic        roundOver,
  input  logic [31:0] maxBid,
  input  logic        X_win,
  input  logic        Y_win,
  input  logic        Z_win,
  output logic [3:0]  C_op,
  output logic [31:0] C_data,
  output logic        C_start,
  output logic        busy,
  output logic        done,
  output logic [2:0]  seq_err,
  output logic [1:0]  winner,
  output logic [31:0] win_amt,
  output logic [7:0]  round_cnt
);
  localparam logic [3:0] OP_NOP       = 4'b0000;
  localparam logic [3:0] OP_UNLOCK    = 4'b0001;
  localparam logic [3:0] OP_LOCK      = 4'b0010;
  localparam logic [3:0] OP_LOAD_X    = 4'b0011;
  localparam logic [3:0] OP_LOAD_Y    = 4'b0100;
  localparam logic [3:0] OP_LOAD_Z    = 4'b0101;
  localparam logic [3:0] OP_SET_TIMER = 4'b1001;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CHECK, S_RUN, S_DONE, S_ERROR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  seq_err_q, seq_err_d;
  logic [1:0]  winner_q, winner_d;
  logic [31:0] win_amt_q, win_amt_d;
  logic [7:0]  round_cnt_q, round_cnt_d;
  logic [31:0] key_q, bal_x_q, bal_y_q, bal_z_q, timer_q;
  logic        rst_done_q;
  logic        cfg_accept;
  logic [3:0]  step_op;
  logic [31:0] step_data;
`ifdef BIDS22_SEQ_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;
`endif

  // rst_done_q keeps cfg_ready low until the first edge after reset release
  assign cfg_ready  = (state_q == S_IDLE) && rst_done_q;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) || (state_q == S_ERROR);
  assign C_start    = (state_q == S_RUN);
  assign seq_err    = seq_err_q;
  assign winner     = winner_q;
  assign win_amt    = win_amt_q;
  assign round_cnt  = round_cnt_q;

  always_comb begin
    step_op   = OP_NOP;
    step_data = '0;
    case (step_q)
      3'd0:    begin step_op = OP_UNLOCK;    step_data = key_q;   end
      3'd1:    begin step_op = OP_LOAD_X;    step_data = bal_x_q; end
      3'd2:    begin step_op = OP_LOAD_Y;    step_data = bal_y_q; end
      3'd3:    begin step_op = OP_LOAD_Z;    step_data = bal_z_q; end
      3'd4:    begin step_op = OP_SET_TIMER; step_data = timer_q; end
      3'd5:    begin step_op = OP_LOCK;      step_data = key_q;   end
      default: begin step_op = OP_NOP;       step_data = '0;      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    seq_err_d   = seq_err_q;
    winner_d    = winner_q;
    win_amt_d   = win_amt_q;
    round_cnt_d = round_cnt_q;
    C_op        = OP_NOP;
    C_data      = '0;
`ifdef BIDS22_SEQ_WATCHDOG_EN
    wd_d        = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_accept) begin
          state_d   = S_ISSUE;
          step_d    = 3'd0;
          seq_err_d = 3'd0;
        end
      end
      S_ISSUE: begin
        if (ready) begin
          C_op    = step_op;
          C_data  = step_data;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (err != 3'd0) begin
          seq_err_d = err;
          state_d   = S_ERROR;
        end else if (step_q == 3'd5) begin
          state_d = S_RUN;
`ifdef BIDS22_SEQ_WATCHDOG_EN
          wd_d    = 16'd0;
`endif
        end else begin
          step_d  = step_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_RUN: begin
        if (roundOver) begin
          win_amt_d   = maxBid;
          round_cnt_d = round_cnt_q + 8'd1;
          state_d     = S_DONE;
          if (X_win)      winner_d = 2'b01;
          else if (Y_win) winner_d = 2'b10;
          else if (Z_win) winner_d = 2'b11;
          else            winner_d = 2'b00;
        end
`ifdef BIDS22_SEQ_WATCHDOG_EN
        // wd_q counts completed RUN cycles; abort at the end of the 65535th
        else if (wd_q == 16'hFFFE) begin
          seq_err_d = 3'b111;
          state_d   = S_ERROR;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      seq_err_q   <= 3'd0;
      winner_q    <= 2'b00;
      win_amt_q   <= 32'd0;
      round_cnt_q <= 8'd0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      seq_err_q   <= seq_err_d;
      winner_q    <= winner_d;
      win_amt_q   <= win_amt_d;
      round_cnt_q <= round_cnt_d;
      rst_done_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q   <= 32'd0;
      bal_x_q <= 32'd0;
      bal_y_q <= 32'd0;
      bal_z_q <= 32'd0;
      timer_q <= 32'd0;
    end else if (cfg_accept) begin
      key_q   <= cfg_key;
      bal_x_q <= cfg_bal_x;
      bal_y_q <= cfg_bal_y;
      bal_z_q <= cfg_bal_z;
      timer_q <= cfg_timer;
    end
  end

`ifdef BIDS22_SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_q <= 16'd0;
    else          wd_q <= wd_d;
  end
`endif

endmodule

// File: doc/bids22_round_seq.md
BIDS22_ROUND_SEQ -- requirements
Module: bids22_round_seq

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-002 SHALL have these ports (name direction width meaning):
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- cfg_valid  in  1  round config offered
- cfg_ready  out  1  sequencer accepts config
- cfg_key  in  32  lock/unlock key
- cfg_bal_x, cfg_bal_y, cfg_bal_z  in  32 each  initial balances
- cfg_timer  in  32  round timer value
- ready  in  1  auction engine ready for op
- err  in  3  engine error code (0 = none)
- roundOver  in  1  engine round complete
- maxBid  in  32  engine winning amount
- X_win, Y_win, Z_win  in  1 each  engine win flags
- C_op  out  4  engine opcode
- C_data  out  32  engine operand
- C_start  out  1  round running
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- seq_err  out  3  latched error of last sequence
- winner  out  2  00 none, 01 X, 10 Y, 11 Z
- win_amt  out  32  captured maxBid
- round_cnt  out  8  completed rounds

Function
REQ-003 SHALL use opcodes NOP=0000, UNLOCK=0001, LOCK=0010, LOAD_X=0011, LOAD_Y=0100, LOAD_Z=0101, SET_TIMER=1001.
REQ-004 SHALL assert cfg_ready only in IDLE and latch all cfg_* inputs on cfg_valid && cfg_ready.
REQ-005 SHALL step through the states IDLE -> UNLOCK -> LOAD_X -> LOAD_Y -> LOAD_Z -> SET_TIMER -> LOCK -> RUN -> DONE -> IDLE.
REQ-006 SHALL give each command state an ISSUE cycle and a CHECK cycle.
- ISSUE: drive the opcode and operand (key, bal_x, bal_y, bal_z, timer, key) for exactly one cycle, only when ready=1.
- While ready=0 in ISSUE: stall with C_op=NOP.
REQ-007 SHALL drive C_op=NOP and C_data=0 in every cycle other than an ISSUE cycle.
REQ-008 SHALL sample err in CHECK; any nonzero value latches into seq_err and moves the FSM to ERROR.
REQ-009 SHALL hold C_start=1 throughout RUN and drop it in the cycle after roundOver is sampled high.
REQ-010 SHALL, on roundOver in RUN:
- capture maxBid into win_amt;
- set winner with priority X > Y > Z (00 if no win flag is set);
- increment round_cnt, wrapping 255 -> 0.
REQ-011 SHALL pulse done for one cycle in DONE and in ERROR; ERROR lasts one cycle, then returns to IDLE with C_start=0.
REQ-012 SHALL clear seq_err to 0 on acceptance of a new config.
REQ-013 SHALL assert busy in every state except IDLE.
REQ-014 SHALL ignore cfg_valid while busy, and ignore roundOver outside RUN.

Reset
REQ-015 SHALL, while reset_n=0 (including mid-sequence), immediately force:
- FSM to IDLE;
- C_op=NOP, C_data=0, C_start=0, busy=0, done=0;
- seq_err=0, winner=00, win_amt=0, round_cnt=0, cfg_ready=0;
- cfg_ready=1 from the first clock edge after reset release.

Configuration
REQ-016 SHALL implement a RUN watchdog under macro BIDS22_SEQ_WATCHDOG_EN.
- Defined: 16-bit counter cleared on RUN entry; if 65535 cycles elapse in RUN without roundOver, drop C_start, set seq_err=3'b111, go to ERROR.
- Undefined: RUN waits indefinitely for roundOver; no counter logic.

Verification
REQ-017 Nominal round: ready=1, key=32'hA5A5_0001, balances 100/200/300, timer 50; roundOver with Y_win=1, maxBid=150.
- C_op sequence 1,3,4,5,9,2, each issue separated by one NOP cycle.
- Then C_start=1 until roundOver; winner=10, win_amt=150, round_cnt=1, done pulses once.
REQ-018 Error abort: err=3'b010 in the CHECK cycle after LOAD_Y.
- seq_err=010, LOAD_Z is never issued, C_start stays 0, done pulses, FSM returns to IDLE.
REQ-019 Stall: ready=0 for 5 cycles at the LOAD_X issue point.
- C_op stays NOP for 5 cycles, then LOAD_X is issued exactly once with C_data=100.
REQ-020 Simultaneous wins and counter wrap: X_win=Z_win=1 at roundOver with round_cnt=255.
- winner=01, round_cnt=0.
REQ-021 Reset mid-RUN: reset_n=0 while C_start=1.
- C_start=0 and all outputs at reset values within the same cycle; cfg_ready=1 after release.
REQ-022 With BIDS22_SEQ_WATCHDOG_EN defined and roundOver withheld: after 65535 RUN cycles, seq_err=111, C_start=0, done pulses.
